// File: rtl/generic_sram_ctrl.sv
// ============================================================================
// Module      : generic_sram_ctrl
// Description : Initiator-side controller for the single-ported generic_sram
//               macro. Turns a valid/ready request stream into SRAM chip-enable
//               cycles and captures one-cycle read data into an in-order
//               response queue. Credit accounting limits read issue so that
//               read data is never lost under response backpressure.
// Options     : SRAM_CTRL_RMW_EN - adds req_wstrb and byte-masked writes,
//               which are performed as a read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module generic_sram_ctrl #(
  parameter  int WORD_W    = 32,
  parameter  int WORDS_N   = 256,
  parameter  int RSP_DEPTH = 3,
  localparam int ADDR_W    = $clog2(WORDS_N)
) (
  input  logic                clk,
  input  logic                arst_n,
  // request stream
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic                req_rnw,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
`ifdef SRAM_CTRL_RMW_EN
  input  logic [WORD_W/8-1:0] req_wstrb,
`endif
  // read response stream
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [WORD_W-1:0]   rsp_rdata,
  // SRAM side
  output logic                sram_ce,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [WORD_W-1:0]   sram_din,
  output logic                sram_rnw,
  input  logic [WORD_W-1:0]   sram_dout
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
`ifdef SRAM_CTRL_RMW_EN
  localparam logic [0:0] ST_RMW_WR = 1'b1;
`endif

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_rdy_en;
  logic              r_inflight;
  logic [WORD_W-1:0] r_q [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_occ;
  logic              w_credit_ok;
  logic              w_acc;
  logic              w_rd_issue;
  logic              w_push;
  logic              w_pop;

  // Advance a queue pointer, wrapping at the (possibly non power of two) depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // A read accepted last cycle already owns a queue slot, so it counts
  // against the credit together with the current occupancy.
  assign w_credit_ok = (32'(r_occ) + 32'(r_inflight)) < 32'(RSP_DEPTH);
  assign req_rdy     = (r_state == ST_IDLE) && r_rdy_en && w_credit_ok;
  assign w_acc       = req_vld && req_rdy;

`ifdef SRAM_CTRL_RMW_EN
  logic [WORD_W/8-1:0] r_wstrb;
  logic [WORD_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   w_merged;
  logic                w_strb_full;
  logic                w_strb_none;
  logic                w_rmw_start;

  assign w_strb_full = &req_wstrb;
  assign w_strb_none = ~|req_wstrb;

  // Merge latched write bytes over the word read back from the SRAM.
  generate
    for (genvar gi = 0; gi < WORD_W / 8; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = r_wstrb[gi] ? r_wdata[8*gi +: 8]
                                               : sram_dout[8*gi +: 8];
    end
  endgenerate

  // Hold the partial-write request for the second half of the RMW.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wstrb <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
    end else if (w_rmw_start) begin
      r_wstrb <= req_wstrb;
      r_wdata <= req_wdata;
      r_addr  <= req_addr;
    end
  end
`endif

  // Drive the SRAM from the accepted request (or the RMW write-back) and pick the next state.
  always_comb begin
    sram_ce     = 1'b0;
    sram_addr   = '0;
    sram_din    = '0;
    sram_rnw    = 1'b0;
    w_rd_issue  = 1'b0;
    w_state_nxt = r_state;
`ifdef SRAM_CTRL_RMW_EN
    w_rmw_start = 1'b0;
    if (r_state == ST_RMW_WR) begin
      sram_ce     = 1'b1;
      sram_addr   = r_addr;
      sram_din    = w_merged;
      sram_rnw    = 1'b0;
      w_state_nxt = ST_IDLE;
    end else
`endif
    if (w_acc) begin
      if (req_rnw) begin
        sram_ce    = 1'b1;
        sram_addr  = req_addr;
        sram_din   = req_wdata;
        sram_rnw   = 1'b1;
        w_rd_issue = 1'b1;
      end
`ifdef SRAM_CTRL_RMW_EN
      else if (w_strb_none) begin
        // Nothing to write: the request is consumed without an SRAM access.
        sram_ce = 1'b0;
      end else if (!w_strb_full) begin
        // Partial write: read the old word now, write the merge next cycle.
        sram_ce     = 1'b1;
        sram_addr   = req_addr;
        sram_din    = req_wdata;
        sram_rnw    = 1'b1;
        w_rmw_start = 1'b1;
        w_state_nxt = ST_RMW_WR;
      end
`endif
      else begin
        sram_ce   = 1'b1;
        sram_addr = req_addr;
        sram_din  = req_wdata;
        sram_rnw  = 1'b0;
      end
    end
  end

  // State, ready enable and the one-cycle read-in-flight marker.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_rdy_en   <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rdy_en   <= 1'b1;
      r_inflight <= w_rd_issue;
    end
  end

  assign w_push    = r_inflight;
  assign w_pop     = rsp_vld && rsp_rdy;
  assign rsp_vld   = (r_occ != '0);
  assign rsp_rdata = r_q[r_rptr];

  // Response queue: capture SRAM data the cycle after a read, pop on handshake.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wptr] <= sram_dout;
        r_wptr      <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_generic_sram_ctrl.sv
// ============================================================================
// Module      : tb_generic_sram_ctrl
// Description : Self-checking bench for generic_sram_ctrl. Contains a
//               behavioural SRAM, a word-level memory model and an expected
//               response queue; directed scenarios followed by random traffic.
// Options     : SRAM_CTRL_RMW_EN - also exercises byte-strobed writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_generic_sram_ctrl;

  localparam int WORD_W    = 32;
  localparam int WORDS_N   = 256;
  localparam int RSP_DEPTH = 3;
  localparam int ADDR_W    = $clog2(WORDS_N);
  localparam int SB_W      = WORD_W / 8;
  localparam int CYC_LIMIT = 50;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              req_vld;
  logic              req_rdy;
  logic              req_rnw;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [SB_W-1:0]   req_wstrb;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [WORD_W-1:0] rsp_rdata;
  logic              sram_ce;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_din;
  logic              sram_rnw;
  logic [WORD_W-1:0] sram_dout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rsp_mode = 0;   // 0: rsp_rdy high, 1: rsp_rdy low, 2: random
  bit m_rdy_en = 1'b0;

  // Reference model state
  logic [WORD_W-1:0] mem     [WORDS_N];
  logic [WORD_W-1:0] ref_mem [WORDS_N];
  logic [WORD_W-1:0] exp_q [$];
  int                acc_q [$];
  bit                rmw_busy = 1'b0;
  logic [ADDR_W-1:0] rmw_addr;
  logic [WORD_W-1:0] rmw_data;
  logic [SB_W-1:0]   rmw_strb;

  always #5 clk = ~clk;

  generic_sram_ctrl #(
    .WORD_W   (WORD_W),
    .WORDS_N  (WORDS_N),
    .RSP_DEPTH(RSP_DEPTH)
  ) u_dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_rnw  (req_rnw),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
`ifdef SRAM_CTRL_RMW_EN
    .req_wstrb(req_wstrb),
`endif
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_rdata(rsp_rdata),
    .sram_ce  (sram_ce),
    .sram_addr(sram_addr),
    .sram_din (sram_din),
    .sram_rnw (sram_rnw),
    .sram_dout(sram_dout)
  );

  task automatic chk(input string tag, input logic [WORD_W-1:0] got,
                     input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WORD_W-1:0] init_word(input int i);
    return 32'hA5C30000 ^ (32'(i) * 32'h00010103);
  endfunction

  function automatic logic [WORD_W-1:0] merge(input logic [WORD_W-1:0] old_w,
                                              input logic [WORD_W-1:0] new_w,
                                              input logic [SB_W-1:0] strb);
    logic [WORD_W-1:0] r;
    r = old_w;
    for (int b = 0; b < SB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Behavioural SRAM: read data valid only in the cycle after a read, junk otherwise.
  initial begin
    for (int i = 0; i < WORDS_N; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (sram_ce && sram_rnw) sram_dout <= mem[sram_addr];
      else                     sram_dout <= $urandom;
      if (sram_ce && !sram_rnw) mem[sram_addr] = sram_din;
    end
  end

  // Response backpressure driver.
  initial begin
    rsp_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       rsp_rdy = 1'b1;
        1:       rsp_rdy = 1'b0;
        default: rsp_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Ready is enabled by the first clock edge seen out of reset.
  initial begin
    forever begin
      @(posedge clk);
      if (arst_n) m_rdy_en = 1'b1;
    end
  end

  // Transaction-level model and checker, sampled mid-cycle.
  initial begin
    bit exp_rdy;
    bit exp_vld;
    for (int i = 0; i < WORDS_N; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        chk("rst_req_rdy", 32'(req_rdy), 0);
        chk("rst_rsp_vld", 32'(rsp_vld), 0);
        chk("rst_sram_ce", 32'(sram_ce), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        exp_q.delete();
        acc_q.delete();
        rmw_busy = 1'b0;
        m_rdy_en = 1'b0;
      end else begin
        exp_rdy = m_rdy_en && !rmw_busy && (exp_q.size() < RSP_DEPTH);
        chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        exp_vld = (acc_q.size() > 0) && (acc_q[0] + 2 <= cyc);
        chk("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
        if (rmw_busy) begin
          ref_mem[rmw_addr] = merge(ref_mem[rmw_addr], rmw_data, rmw_strb);
          rmw_busy = 1'b0;
        end
        if (rsp_vld && rsp_rdy && exp_q.size() > 0) begin
          chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        if (req_vld && req_rdy) begin
          if (req_rnw) begin
            exp_q.push_back(ref_mem[req_addr]);
            acc_q.push_back(cyc);
          end else begin
`ifdef SRAM_CTRL_RMW_EN
            if (&req_wstrb) begin
              ref_mem[req_addr] = req_wdata;
            end else if (|req_wstrb) begin
              rmw_busy = 1'b1;
              rmw_addr = req_addr;
              rmw_data = req_wdata;
              rmw_strb = req_wstrb;
            end
`else
            ref_mem[req_addr] = req_wdata;
`endif
          end
        end
      end
      cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic do_req(input logic rnw, input logic [ADDR_W-1:0] a,
                        input logic [WORD_W-1:0] d, input logic [SB_W-1:0] s);
    bit got;
    bit done;
    done      = 1'b0;
    req_vld   = 1'b1;
    req_rnw   = rnw;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    for (int n = 0; n < CYC_LIMIT && !done; n++) begin
      @(negedge clk);
      got = req_rdy;
      @(posedge clk);
      #1;
      if (got) done = 1'b1;
    end
    if (!done) chk("req_accept_timeout", 0, 1);
    req_vld = 1'b0;
  endtask

  initial begin
    int t0;
    int cnt;
    bit got;
    req_vld   = 1'b0;
    req_rnw   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '1;
    arst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    idle(2);

    // Write then read back; latency is checked by the model on rsp_vld.
    do_req(1'b0, 8'd5, 32'hDEADBEEF, '1);
    do_req(1'b1, 8'd5, '0, '1);
    idle(4);

    // Preload 0..7, then stream eight reads back to back.
    for (int a = 0; a < 8; a++) do_req(1'b0, 8'(a), 32'h100 + 32'(a), '1);
    idle(1);
    t0 = cyc;
    for (int a = 0; a < 8; a++) do_req(1'b1, 8'(a), '0, '1);
    chk("stream_cycles", 32'(cyc - t0), 8);
    idle(6);

    // Backpressure: only RSP_DEPTH reads may be accepted.
    rsp_mode = 1;
    idle(2);
    req_vld = 1'b1;
    req_rnw = 1'b1;
    req_addr = '0;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      got = req_rdy;
      @(posedge clk);
      #1;
      if (got) begin
        cnt++;
        req_addr = req_addr + 1'b1;
      end
    end
    req_vld = 1'b0;
    chk("bp_accepts", 32'(cnt), RSP_DEPTH);
    rsp_mode = 0;
    idle(6);
    chk("bp_drained", 32'(exp_q.size()), 0);

    // Write then read the same address on the next cycle.
    do_req(1'b0, 8'd7, 32'hCAFEF00D, '1);
    do_req(1'b1, 8'd7, '0, '1);
    idle(4);

`ifdef SRAM_CTRL_RMW_EN
    // Partial write merges bytes and stalls the request side for one cycle.
    do_req(1'b0, 8'd9, 32'h11223344, '1);
    do_req(1'b0, 8'd9, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    chk("rmw_rdy_low", 32'(req_rdy), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rmw_rdy_back", 32'(req_rdy), 1);
    @(posedge clk);
    #1;
    do_req(1'b1, 8'd9, '0, '1);
    idle(4);
    chk("rmw_mem", mem[9], 32'h11BB33DD);

    // Reset during the write-back cycle abandons the merge.
    do_req(1'b0, 8'd9, 32'h11223344, '1);
    do_req(1'b0, 8'd9, 32'hAABBCCDD, 4'b0101);
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    chk("rst_no_write", mem[9], 32'h11223344);
    @(negedge clk);
    chk("rst_rdy_first", 32'(req_rdy), 0);
    chk("rst_vld_first", 32'(rsp_vld), 0);
    @(posedge clk);
    #1;
    do_req(1'b1, 8'd9, '0, '1);
    idle(4);
`endif

    // Random traffic with random backpressure over a small address window.
    rsp_mode = 2;
    for (int n = 0; n < 400; n++) begin
      logic [SB_W-1:0] s;
      case ($urandom_range(0, 3))
        0:       s = '0;
        1:       s = '1;
        default: s = SB_W'($urandom);
      endcase
`ifndef SRAM_CTRL_RMW_EN
      s = '1;
`endif
      if ($urandom_range(0, 4) == 0) idle(1);
      else do_req(1'($urandom), 8'($urandom_range(0, 15)), $urandom, s);
    end

    // Drain and sweep memory.
    rsp_mode = 0;
    for (int n = 0; n < CYC_LIMIT && exp_q.size() > 0; n++) idle(1);
    chk("drain_empty", 32'(exp_q.size()), 0);
    idle(3);
    for (int i = 0; i < WORDS_N; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
